// File: rtl/sap_control_sequencer.sv
// -----------------------------------------------------------------------------
// sap_control_sequencer
//
// Microcode sequencer for the SAP-1 datapath. A micro-step counter (T0..T5)
// and an opcode decoder generate the control word for the program counter,
// MAR, RAM, instruction register, A/B registers, ALU and output register.
// Each instruction is fetched in T0/T1 and executed in T2 onward, with a
// variable number of execute steps per opcode. The sequencer also holds the
// carry/zero flags latched from the ALU, and a sticky halt flag set by HLT.
//
// Optional feature macro: SAP_JUMP_EN
//   defined   : opcodes 6 (JMP), 7 (JC), 8 (JZ) load the PC from the IR.
//   undefined : opcodes 6..8 decode as NOP and pc_load is tied to 0.
//
// Ports
//   clk        in   system clock, all state changes on the rising edge
//   reset      in   asynchronous active-high reset (step, flags, halt)
//   run        in   step enable; advance only when run=1 and halted=0
//   opcode[3:0]in   upper nibble of the IR, valid from T2
//   alu_c      in   live ALU carry
//   alu_z      in   live ALU zero
//   pc_out, pc_inc, pc_load, mar_in, ram_out, ram_write, ir_in, ir_out,
//   a_in, a_out, b_in, alu_out, alu_sub, out_in
//              out  control word (combinational decode of step/opcode/flags)
//   flag_c     out  latched carry flag
//   flag_z     out  latched zero flag
//   halted     out  HLT has executed (cleared only by reset)
//   step[2:0]  out  current micro-step, 0..5
// -----------------------------------------------------------------------------
module sap_control_sequencer (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic [3:0] opcode,
  input  logic       alu_c,
  input  logic       alu_z,
  output logic       pc_out,
  output logic       pc_inc,
  output logic       pc_load,
  output logic       mar_in,
  output logic       ram_out,
  output logic       ram_write,
  output logic       ir_in,
  output logic       ir_out,
  output logic       a_in,
  output logic       a_out,
  output logic       b_in,
  output logic       alu_out,
  output logic       alu_sub,
  output logic       out_in,
  output logic       flag_c,
  output logic       flag_z,
  output logic       halted,
  output logic [2:0] step
);

  // Micro-step state. T5 is reserved and only ever reached by a fault; it
  // falls straight back to T0.
  typedef enum logic [2:0] {
    T0 = 3'd0,
    T1 = 3'd1,
    T2 = 3'd2,
    T3 = 3'd3,
    T4 = 3'd4,
    T5 = 3'd5
  } step_t;

  // Decoded instruction class.
  typedef enum logic [3:0] {
    I_NOP,
    I_LDA,
    I_ADD,
    I_SUB,
    I_STA,
    I_LDI,
    I_JMP,
    I_JC,
    I_JZ,
    I_OUT,
    I_HLT
  } instr_t;

  step_t  step_q, step_d;
  logic   flag_c_q, flag_c_d;
  logic   flag_z_q, flag_z_d;
  logic   halted_q, halted_d;
  instr_t instr;
  logic   advance;

`ifdef SAP_JUMP_EN
  logic   pc_load_c;
`endif

  // ---------------------------------------------------------------------------
  // Opcode decode. Unused opcodes (and the jumps when jumps are disabled)
  // collapse to NOP so that every opcode has a defined 3-cycle behaviour.
  // ---------------------------------------------------------------------------
  always_comb begin
    instr = I_NOP;
    unique case (opcode)
      4'h1:    instr = I_LDA;
      4'h2:    instr = I_ADD;
      4'h3:    instr = I_SUB;
      4'h4:    instr = I_STA;
      4'h5:    instr = I_LDI;
`ifdef SAP_JUMP_EN
      4'h6:    instr = I_JMP;
      4'h7:    instr = I_JC;
      4'h8:    instr = I_JZ;
`endif
      4'hE:    instr = I_OUT;
      4'hF:    instr = I_HLT;
      default: instr = I_NOP;
    endcase
  end

  // The control word is live only while the machine actually steps; reset,
  // pause and halt all blank it so no consumer acts on a held step.
  assign advance = run & ~halted_q & ~reset;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step_q   <= T0;
      flag_c_q <= 1'b0;
      flag_z_q <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      step_q   <= step_d;
      flag_c_q <= flag_c_d;
      flag_z_q <= flag_z_d;
      halted_q <= halted_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-step and control-word decode
  // ---------------------------------------------------------------------------
  always_comb begin
    step_d    = step_q;
    flag_c_d  = flag_c_q;
    flag_z_d  = flag_z_q;
    halted_d  = halted_q;
    pc_out    = 1'b0;
    pc_inc    = 1'b0;
    mar_in    = 1'b0;
    ram_out   = 1'b0;
    ram_write = 1'b0;
    ir_in     = 1'b0;
    ir_out    = 1'b0;
    a_in      = 1'b0;
    a_out     = 1'b0;
    b_in      = 1'b0;
    alu_out   = 1'b0;
    alu_sub   = 1'b0;
    out_in    = 1'b0;
`ifdef SAP_JUMP_EN
    pc_load_c = 1'b0;
`endif

    if (advance) begin
      // Most steps end the instruction; the longer ones override below.
      step_d = T0;
      unique case (step_q)
        T0: begin
          pc_out = 1'b1;
          mar_in = 1'b1;
          step_d = T1;
        end

        T1: begin
          ram_out = 1'b1;
          ir_in   = 1'b1;
          pc_inc  = 1'b1;
          step_d  = T2;
        end

        T2: begin
          case (instr)
            I_LDA, I_ADD, I_SUB, I_STA: begin
              // Operand address from the IR low nibble into the MAR.
              ir_out = 1'b1;
              mar_in = 1'b1;
              step_d = T3;
            end
            I_LDI: begin
              ir_out = 1'b1;
              a_in   = 1'b1;
            end
            I_OUT: begin
              a_out  = 1'b1;
              out_in = 1'b1;
            end
            I_HLT: begin
              halted_d = 1'b1;
            end
`ifdef SAP_JUMP_EN
            // Conditions use the registered flags, never the live ALU
            // outputs, so an untaken jump simply idles for one step.
            I_JMP: begin
              ir_out    = 1'b1;
              pc_load_c = 1'b1;
            end
            I_JC: begin
              ir_out    = flag_c_q;
              pc_load_c = flag_c_q;
            end
            I_JZ: begin
              ir_out    = flag_z_q;
              pc_load_c = flag_z_q;
            end
`endif
            default: begin
              // NOP: no outputs.
            end
          endcase
        end

        T3: begin
          case (instr)
            I_LDA: begin
              ram_out = 1'b1;
              a_in    = 1'b1;
            end
            I_ADD, I_SUB: begin
              ram_out = 1'b1;
              b_in    = 1'b1;
              step_d  = T4;
            end
            I_STA: begin
              a_out     = 1'b1;
              ram_write = 1'b1;
            end
            default: begin
              // Other instructions never reach T3.
            end
          endcase
        end

        T4: begin
          if (instr == I_ADD || instr == I_SUB) begin
            alu_out  = 1'b1;
            a_in     = 1'b1;
            alu_sub  = (instr == I_SUB);
            // Flags capture the ALU result on the same edge A takes it.
            flag_c_d = alu_c;
            flag_z_d = alu_z;
          end
        end

        default: begin
          // Reserved step: no outputs, recover to T0.
          step_d = T0;
        end
      endcase
    end
  end

`ifdef SAP_JUMP_EN
  assign pc_load = pc_load_c;
`else
  assign pc_load = 1'b0;
`endif

  assign flag_c = flag_c_q;
  assign flag_z = flag_z_q;
  assign halted = halted_q;
  assign step   = step_q;

endmodule

// File: tb/tb_sap_control_sequencer.sv
module tb_sap_control_sequencer;

  logic       clk;
  logic       reset;
  logic       run;
  logic [3:0] opcode;
  logic       alu_c;
  logic       alu_z;
  logic       pc_out, pc_inc, pc_load, mar_in, ram_out, ram_write, ir_in;
  logic       ir_out, a_in, a_out, b_in, alu_out, alu_sub, out_in;
  logic       flag_c, flag_z, halted;
  logic [2:0] step;

  int checks;
  int failures;

`ifdef SAP_JUMP_EN
  localparam bit JUMP_EN = 1'b1;
`else
  localparam bit JUMP_EN = 1'b0;
`endif

  localparam logic [13:0] PC_OUT    = 14'h2000;
  localparam logic [13:0] PC_INC    = 14'h1000;
  localparam logic [13:0] PC_LOAD   = 14'h0800;
  localparam logic [13:0] MAR_IN    = 14'h0400;
  localparam logic [13:0] RAM_OUT   = 14'h0200;
  localparam logic [13:0] RAM_WRITE = 14'h0100;
  localparam logic [13:0] IR_IN     = 14'h0080;
  localparam logic [13:0] IR_OUT    = 14'h0040;
  localparam logic [13:0] A_IN      = 14'h0020;
  localparam logic [13:0] A_OUT     = 14'h0010;
  localparam logic [13:0] B_IN      = 14'h0008;
  localparam logic [13:0] ALU_OUT   = 14'h0004;
  localparam logic [13:0] ALU_SUB   = 14'h0002;
  localparam logic [13:0] OUT_IN    = 14'h0001;
  localparam logic [13:0] FETCH0    = PC_OUT | MAR_IN;
  localparam logic [13:0] FETCH1    = RAM_OUT | IR_IN | PC_INC;

  logic [13:0] ctrl;
  assign ctrl = {pc_out, pc_inc, pc_load, mar_in, ram_out, ram_write, ir_in,
                 ir_out, a_in, a_out, b_in, alu_out, alu_sub, out_in};

  sap_control_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .run       (run),
    .opcode    (opcode),
    .alu_c     (alu_c),
    .alu_z     (alu_z),
    .pc_out    (pc_out),
    .pc_inc    (pc_inc),
    .pc_load   (pc_load),
    .mar_in    (mar_in),
    .ram_out   (ram_out),
    .ram_write (ram_write),
    .ir_in     (ir_in),
    .ir_out    (ir_out),
    .a_in      (a_in),
    .a_out     (a_out),
    .b_in      (b_in),
    .alu_out   (alu_out),
    .alu_sub   (alu_sub),
    .out_in    (out_in),
    .flag_c    (flag_c),
    .flag_z    (flag_z),
    .halted    (halted),
    .step      (step)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every task starts and ends just after a falling edge with step expected 0.

  task automatic test_reset();
    reset = 1'b1; run = 1'b1; opcode = 4'h1; alu_c = 1'b1; alu_z = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (step !== 3'd0) begin failures++; $display("FAIL reset_step got=%0d exp=0", step); end
    checks++; if (ctrl !== 14'h0) begin failures++; $display("FAIL reset_ctrl got=%h exp=0000", ctrl); end
    checks++; if (halted !== 1'b0) begin failures++; $display("FAIL reset_halted got=%b exp=0", halted); end
    checks++; if ({flag_c, flag_z} !== 2'b00) begin failures++; $display("FAIL reset_flags got=%b exp=00", {flag_c, flag_z}); end
    $display("txn reset: step=%0d ctrl=%h halted=%b flags=%b%b", step, ctrl, halted, flag_c, flag_z);
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  task automatic test_lda();
    logic [13:0] exp_ctrl [4];
    exp_ctrl[0] = FETCH0;
    exp_ctrl[1] = FETCH1;
    exp_ctrl[2] = IR_OUT | MAR_IN;
    exp_ctrl[3] = RAM_OUT | A_IN;
    opcode = 4'h1;
    #1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin @(negedge clk); #1; end
      checks++; if (step !== 3'(i)) begin failures++; $display("FAIL lda_step got=%0d exp=%0d", step, i); end
      checks++; if (ctrl !== exp_ctrl[i]) begin failures++; $display("FAIL lda_ctrl_T%0d got=%h exp=%h", i, ctrl, exp_ctrl[i]); end
    end
    @(negedge clk); #1;
    checks++; if (step !== 3'd0) begin failures++; $display("FAIL lda_end_step got=%0d exp=0", step); end
    $display("txn LDA: 4 steps, returned to step=%0d", step);
  endtask

  task automatic test_sub();
    logic [13:0] exp_ctrl [5];
    exp_ctrl[0] = FETCH0;
    exp_ctrl[1] = FETCH1;
    exp_ctrl[2] = IR_OUT | MAR_IN;
    exp_ctrl[3] = RAM_OUT | B_IN;
    exp_ctrl[4] = ALU_OUT | A_IN | ALU_SUB;
    opcode = 4'h3; alu_c = 1'b1; alu_z = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin @(negedge clk); #1; end
      checks++; if (step !== 3'(i)) begin failures++; $display("FAIL sub_step got=%0d exp=%0d", step, i); end
      checks++; if (ctrl !== exp_ctrl[i]) begin failures++; $display("FAIL sub_ctrl_T%0d got=%h exp=%h", i, ctrl, exp_ctrl[i]); end
      checks++; if ({flag_c, flag_z} !== 2'b00) begin failures++; $display("FAIL sub_flags_early_T%0d got=%b exp=00", i, {flag_c, flag_z}); end
    end
    @(negedge clk); #1;
    checks++; if (step !== 3'd0) begin failures++; $display("FAIL sub_end_step got=%0d exp=0", step); end
    checks++; if ({flag_c, flag_z} !== 2'b11) begin failures++; $display("FAIL sub_flags got=%b exp=11", {flag_c, flag_z}); end
    $display("txn SUB: flags now %b%b", flag_c, flag_z);
    // NOP with live ALU flags cleared must leave the latched flags alone.
    opcode = 4'h0; alu_c = 1'b0; alu_z = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
    end
    checks++; if (step !== 3'd0) begin failures++; $display("FAIL nop_end_step got=%0d exp=0", step); end
    checks++; if ({flag_c, flag_z} !== 2'b11) begin failures++; $display("FAIL nop_flags_hold got=%b exp=11", {flag_c, flag_z}); end
    $display("txn NOP: flags held %b%b", flag_c, flag_z);
  endtask

  task automatic test_jumps(input logic fc, input logic fz);
    logic [13:0] exp_t2;
    logic        taken;
    for (int k = 6; k <= 8; k++) begin
      taken  = JUMP_EN && ((k == 6) || (k == 7 && fc) || (k == 8 && fz));
      exp_t2 = taken ? (IR_OUT | PC_LOAD) : 14'h0;
      opcode = 4'(k);
      // Live ALU flags opposite to the latched ones must not matter.
      alu_c = ~fc; alu_z = ~fz;
      @(negedge clk); @(negedge clk); #1;
      checks++; if (step !== 3'd2) begin failures++; $display("FAIL jump%0d_step got=%0d exp=2", k, step); end
      checks++; if (ctrl !== exp_t2) begin failures++; $display("FAIL jump%0d_ctrl_T2 got=%h exp=%h", k, ctrl, exp_t2); end
      @(negedge clk); #1;
      checks++; if (step !== 3'd0) begin failures++; $display("FAIL jump%0d_end_step got=%0d exp=0", k, step); end
      $display("txn JUMP op=%0d flags=%b%b taken=%b", k, fc, fz, taken);
    end
  endtask

  task automatic test_short_ops();
    logic [3:0]  ops  [8];
    int          lens [8];
    logic [13:0] e2   [8];
    logic [13:0] e3   [8];
    ops[0] = 4'h5; lens[0] = 3; e2[0] = IR_OUT | A_IN;   e3[0] = 14'h0;
    ops[1] = 4'hE; lens[1] = 3; e2[1] = A_OUT | OUT_IN;  e3[1] = 14'h0;
    ops[2] = 4'h4; lens[2] = 4; e2[2] = IR_OUT | MAR_IN; e3[2] = A_OUT | RAM_WRITE;
    ops[3] = 4'h9; lens[3] = 3; e2[3] = 14'h0;           e3[3] = 14'h0;
    ops[4] = 4'hA; lens[4] = 3; e2[4] = 14'h0;           e3[4] = 14'h0;
    ops[5] = 4'hB; lens[5] = 3; e2[5] = 14'h0;           e3[5] = 14'h0;
    ops[6] = 4'hC; lens[6] = 3; e2[6] = 14'h0;           e3[6] = 14'h0;
    ops[7] = 4'hD; lens[7] = 3; e2[7] = 14'h0;           e3[7] = 14'h0;
    for (int n = 0; n < 8; n++) begin
      opcode = ops[n];
      @(negedge clk); @(negedge clk); #1;
      checks++; if (ctrl !== e2[n]) begin failures++; $display("FAIL op%h_ctrl_T2 got=%h exp=%h", ops[n], ctrl, e2[n]); end
      if (lens[n] == 4) begin
        @(negedge clk); #1;
        checks++; if (ctrl !== e3[n]) begin failures++; $display("FAIL op%h_ctrl_T3 got=%h exp=%h", ops[n], ctrl, e3[n]); end
      end
      @(negedge clk); #1;
      checks++; if (step !== 3'd0) begin failures++; $display("FAIL op%h_end_step got=%0d exp=0", ops[n], step); end
      $display("txn op=%h len=%0d T2=%h", ops[n], lens[n], e2[n]);
    end
  endtask

  task automatic test_pause_add();
    opcode = 4'h2; alu_c = 1'b0; alu_z = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (step !== 3'd3) begin failures++; $display("FAIL pause_pre_step got=%0d exp=3", step); end
    checks++; if (ctrl !== (RAM_OUT | B_IN)) begin failures++; $display("FAIL pause_pre_ctrl got=%h exp=%h", ctrl, RAM_OUT | B_IN); end
    run = 1'b0;
    #1;
    checks++; if (ctrl !== 14'h0) begin failures++; $display("FAIL pause_drop_ctrl got=%h exp=0000", ctrl); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      checks++; if (step !== 3'd3) begin failures++; $display("FAIL pause_hold_step got=%0d exp=3", step); end
      checks++; if (ctrl !== 14'h0) begin failures++; $display("FAIL pause_hold_ctrl got=%h exp=0000", ctrl); end
    end
    run = 1'b1;
    #1;
    checks++; if (ctrl !== (RAM_OUT | B_IN)) begin failures++; $display("FAIL pause_resume_T3 got=%h exp=%h", ctrl, RAM_OUT | B_IN); end
    @(negedge clk); #1;
    checks++; if (step !== 3'd4) begin failures++; $display("FAIL pause_resume_step got=%0d exp=4", step); end
    checks++; if (ctrl !== (ALU_OUT | A_IN)) begin failures++; $display("FAIL add_ctrl_T4 got=%h exp=%h", ctrl, ALU_OUT | A_IN); end
    @(negedge clk); #1;
    checks++; if (step !== 3'd0) begin failures++; $display("FAIL add_end_step got=%0d exp=0", step); end
    checks++; if ({flag_c, flag_z} !== 2'b00) begin failures++; $display("FAIL add_flags got=%b exp=00", {flag_c, flag_z}); end
    $display("txn ADD with pause: flags now %b%b", flag_c, flag_z);
  endtask

  task automatic test_reset_mid();
    logic [13:0] exp_ctrl [5];
    exp_ctrl[0] = FETCH0;
    exp_ctrl[1] = FETCH1;
    exp_ctrl[2] = IR_OUT | MAR_IN;
    exp_ctrl[3] = RAM_OUT | B_IN;
    exp_ctrl[4] = ALU_OUT | A_IN;
    // First ADD sets both flags so the reset clearing them is visible.
    opcode = 4'h2; alu_c = 1'b1; alu_z = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    checks++; if ({flag_c, flag_z} !== 2'b11) begin failures++; $display("FAIL add2_flags got=%b exp=11", {flag_c, flag_z}); end
    repeat (3) @(negedge clk);
    #1;
    checks++; if (step !== 3'd3) begin failures++; $display("FAIL rmid_pre_step got=%0d exp=3", step); end
    reset = 1'b1;
    #1;
    checks++; if (ctrl !== 14'h0) begin failures++; $display("FAIL rmid_ctrl got=%h exp=0000", ctrl); end
    checks++; if (step !== 3'd0) begin failures++; $display("FAIL rmid_step got=%0d exp=0", step); end
    checks++; if ({flag_c, flag_z} !== 2'b00) begin failures++; $display("FAIL rmid_flags got=%b exp=00", {flag_c, flag_z}); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin @(negedge clk); #1; end
      checks++; if (ctrl !== exp_ctrl[i]) begin failures++; $display("FAIL rmid_after_T%0d got=%h exp=%h", i, ctrl, exp_ctrl[i]); end
    end
    @(negedge clk); #1;
    $display("txn reset mid-ADD: restarted at T0, step=%0d", step);
  endtask

  task automatic test_halt();
    opcode = 4'hF;
    @(negedge clk); @(negedge clk); #1;
    checks++; if (step !== 3'd2) begin failures++; $display("FAIL hlt_step_T2 got=%0d exp=2", step); end
    checks++; if (ctrl !== 14'h0) begin failures++; $display("FAIL hlt_ctrl_T2 got=%h exp=0000", ctrl); end
    checks++; if (halted !== 1'b0) begin failures++; $display("FAIL hlt_early got=%b exp=0", halted); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      checks++; if (halted !== 1'b1) begin failures++; $display("FAIL hlt_halted got=%b exp=1", halted); end
      checks++; if (step !== 3'd0) begin failures++; $display("FAIL hlt_step got=%0d exp=0", step); end
      checks++; if (ctrl !== 14'h0) begin failures++; $display("FAIL hlt_ctrl got=%h exp=0000", ctrl); end
    end
    $display("txn HLT: halted=%b step=%0d over 10 cycles", halted, step);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (halted !== 1'b0) begin failures++; $display("FAIL hlt_clear got=%b exp=0", halted); end
    checks++; if (ctrl !== FETCH0) begin failures++; $display("FAIL hlt_restart_ctrl got=%h exp=%h", ctrl, FETCH0); end
    $display("txn reset after HLT: halted=%b ctrl=%h", halted, ctrl);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1; run = 1'b0; opcode = 4'h0; alu_c = 1'b0; alu_z = 1'b0;
    test_reset();
    test_lda();
    test_sub();
    test_jumps(1'b1, 1'b1);
    test_short_ops();
    test_pause_add();
    test_jumps(1'b0, 1'b0);
    test_reset_mid();
    test_halt();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
